// File: rtl/rst_seq_ctrl.sv
// rtl/rst_seq_ctrl.sv - reset synchronizer and staggered release sequencer with software reset handshake
module rst_seq_ctrl #(
    parameter int SYNC_STAGES = 2,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGGER     = 4,
    parameter int NUM_OUT     = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               sw_rst_req_i,
    output logic               sw_rst_ack_o,
    output logic [NUM_OUT-1:0] rst_o,
    output logic               busy_o
);

    localparam int MAX_CNT = (HOLD_CYCLES > STAGGER) ? HOLD_CYCLES : STAGGER;
    localparam int CW      = $clog2(MAX_CNT + 1);
    localparam int SW      = SYNC_STAGES - 1;

    typedef enum logic [2:0] {
        SYNC,
        HOLD,
        RELEASE,
        RUN,
        ACK
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [CW-1:0]      cnt;
    logic [CW-1:0]      cnt_nxt;
    logic [NUM_OUT-1:0] rst_nxt;
    logic [NUM_OUT-1:0] rst_shift;
    logic               busy_nxt;
    logic               ack_nxt;
    logic               sw_seq;
    logic               sw_seq_nxt;
    logic               step;
    logic [SW-1:0]      sync_q;
    logic               sync_done;

    // The SYNC state register acts as the final synchronizer stage, so the
    // explicit chain is one flop shorter than SYNC_STAGES.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= (sync_q << 1) | SW'(1);
        end
    end

    assign sync_done = sync_q[SW-1];

    // Outputs release lowest index first by shifting a zero in from bit 0.
    assign rst_shift = rst_o << 1;
    assign step      = ((state == HOLD)    && (cnt == CW'(HOLD_CYCLES - 1))) ||
                       ((state == RELEASE) && (cnt == CW'(STAGGER - 1)));

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt + CW'(1);
        rst_nxt    = rst_o;
        ack_nxt    = sw_rst_ack_o;
        sw_seq_nxt = sw_seq;
        case (state)
            SYNC: begin
                cnt_nxt = '0;
                if (sync_done) begin
                    state_nxt = HOLD;
                end
            end
            HOLD, RELEASE: begin
                if (step) begin
                    cnt_nxt = '0;
                    rst_nxt = rst_shift;
                    if (rst_shift == '0) begin
                        state_nxt = sw_seq ? ACK : RUN;
                        ack_nxt   = sw_seq;
                    end else begin
                        state_nxt = RELEASE;
                    end
                end
            end
            RUN: begin
                cnt_nxt = '0;
                if (sw_rst_req_i) begin
                    state_nxt  = HOLD;
                    rst_nxt    = '1;
                    sw_seq_nxt = 1'b1;
                end
            end
            ACK: begin
                cnt_nxt = '0;
                if (!sw_rst_req_i) begin
                    state_nxt  = RUN;
                    ack_nxt    = 1'b0;
                    sw_seq_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = SYNC;
                cnt_nxt   = '0;
            end
        endcase
        busy_nxt = |rst_nxt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= SYNC;
            cnt          <= '0;
            rst_o        <= '1;
            busy_o       <= 1'b1;
            sw_rst_ack_o <= 1'b0;
            sw_seq       <= 1'b0;
        end else begin
            state        <= state_nxt;
            cnt          <= cnt_nxt;
            rst_o        <= rst_nxt;
            busy_o       <= busy_nxt;
            sw_rst_ack_o <= ack_nxt;
            sw_seq       <= sw_seq_nxt;
        end
    end

endmodule

// File: doc/rst_seq_ctrl.md
Name: rst_seq_ctrl

Overview:
Reset generator and sequencer that drives the synchronous resets consumed by the team's flop-based blocks.
- Takes the board-level asynchronous active-low reset and asserts every downstream reset immediately.
- Synchronizes release, holds reset for a fixed count, then releases NUM_OUT downstream resets in staggered order.
- Also accepts a software reset request over a 4-phase req/ack handshake, re-running the hold/release sequence without touching the async input.

Parameters:
SYNC_STAGES, 2, depth of the reset-release synchronizer (legal range >= 2)
HOLD_CYCLES, 16, cycles all outputs stay asserted after synchronized release or software request (legal range >= 1)
STAGGER, 4, cycles between consecutive output releases (legal range >= 1)
NUM_OUT, 3, number of downstream reset outputs (legal range >= 1)

Ports:
clk  input  1  single clock, rising-edge
reset  input  1  asynchronous, active-low reset (0 = in reset)
sw_rst_req_i  input  1  software reset request, level, 4-phase handshake
sw_rst_ack_o  output  1  software reset complete acknowledge
rst_o  output  NUM_OUT  active-high synchronous resets to downstream blocks; bit 0 releases first
busy_o  output  1  high while any rst_o bit is asserted

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-low.
- While reset = 0, immediately and without a clock edge:
  - rst_o = all ones, busy_o = 1, sw_rst_ack_o = 0.
  - Synchronizer chain cleared to 0; FSM in SYNC; counter = 0.
- Synchronizer: a 1 shifts in on each rising edge with reset = 1; sync_done = last stage. Deassertion is never used combinationally.
- Edge numbering: edge 1 is the first rising edge with reset = 1.
- FSM states:
  - SYNC: wait for sync_done (true after edge SYNC_STAGES), then enter HOLD.
  - HOLD: count HOLD_CYCLES, then enter RELEASE.
  - RELEASE: clear one rst_o bit per step, in index order, STAGGER cycles apart. After the last bit, enter RUN (power-on) or ACK (software).
  - RUN: idle.
  - ACK: hold the software acknowledge.
- Power-on timing. All changes are registered, visible after the named edge:
  - rst_o[i] falls at edge SYNC_STAGES + HOLD_CYCLES + i*STAGGER.
  - Defaults: bit0 @18, bit1 @22, bit2 @26.
  - busy_o falls with the last bit.
- Software reset:
  - In RUN, sw_rst_req_i = 1 sampled at edge e sets rst_o = all ones and busy_o = 1 at edge e, and enters HOLD.
  - rst_o[i] falls at edge e + HOLD_CYCLES + i*STAGGER.
  - sw_rst_ack_o rises at the same edge the last bit falls; FSM enters ACK.
  - ACK: ack stays 1 until sw_rst_req_i = 0 is sampled. At that edge ack = 0 and FSM returns to RUN.
  - A req still high on entering RUN is not possible, because ACK exits only on req low.
- Boundary conditions:
  - sw_rst_req_i during SYNC/HOLD/RELEASE of power-on: ignored, no ack. If req is still high once RUN is reached, it is honoured at the first RUN edge.
  - sw_rst_req_i rising while in ACK: ignored; a new request needs req low then high.
  - reset = 0 at any time, including mid-software-sequence or in ACK: async abort to the reset values above. A pending request is dropped and ack is never issued for it.
  - reset pulse shorter than one clock still asserts all outputs and forces the full SYNC+HOLD+RELEASE sequence.
  - NUM_OUT = 1: RELEASE lasts exactly one step; stagger is unused.
  - Counter width = clog2(max(HOLD_CYCLES, STAGGER) + 1); counter never wraps, it is cleared on every state entry.
- Outputs: all registered; no combinational path from any input to any output. Exception: rst_o/busy_o assertion from reset via async clear.

Test Plan:
1. Power-on, defaults: reset low 3 cycles, then high → rst_o = 3'b111 through edge 17; 3'b110 after edge 18; 3'b100 after 22; 3'b000 and busy_o = 0 after 26; ack stays 0.
2. Software reset: after RUN, raise sw_rst_req_i at edge 40 → rst_o = 3'b111 after 40; bits clear after 56/60/64; ack = 1 after 64. Drop req at edge 70 → ack = 0 after 70, FSM in RUN.
3. Request during power-on: req high from edge 5 and held → no effect until RUN; sequence restarts at edge 27; ack after 27+16+8 = edge 51.
4. Mid-sequence abort: software sequence running, pull reset low between edges while rst_o = 3'b100 → rst_o = 3'b111 and ack = 0 with no clock edge. After release, full power-on timing of test 1 repeats.
5. Glitch reset: 2 ns low pulse between clock edges → all outputs assert immediately; release timing matches test 1 counted from the next edge.
6. Parameter sweep, NUM_OUT = 1, HOLD_CYCLES = 1, SYNC_STAGES = 3 → rst_o[0] falls at edge 4; software req at edge e → rst_o falls at e+1 and ack = 1 at e+1.
